// File: rtl/wifisystem_nios2_qsys_0_oci_dct_packer_pkg.sv
// Shared sizing, FSM encodings and packing helper for the OCI DCT trace-word packer.
// The sink-side bench reuses these so both ends agree on word geometry.
package wifisystem_nios2_qsys_0_oci_dct_packer_pkg;

  localparam int CODE_W = 2;
  localparam int DEPTH  = 15;
  localparam int BUF_W  = CODE_W * DEPTH;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } dct_state_e;

  // Newest code lands in the low bits; the oldest shifts toward the top.
  function automatic logic [BUF_W-1:0] dct_shift_in(input logic [BUF_W-1:0] buf_in,
                                                    input logic [CODE_W-1:0] code_in);
    return {buf_in[BUF_W-CODE_W-1:0], code_in};
  endfunction

endpackage

// File: rtl/wifisystem_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit DCT codes into 30-bit trace words with a valid/ready output
// and sequences the end-of-test drain.
module wifisystem_nios2_qsys_0_oci_dct_packer
  import wifisystem_nios2_qsys_0_oci_dct_packer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [1:0]  code,
  output logic        code_ready,
  input  logic        flush,
  input  logic        test_ending,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        test_has_ended
);

  dct_state_e       r_state, w_state_n;
  logic [BUF_W-1:0] r_acc_buf, w_acc_buf_n, w_sum_buf, w_xfer_buf;
  logic [CNT_W-1:0] r_acc_cnt, w_acc_cnt_n, w_sum_cnt, w_xfer_cnt;
  logic             r_flush_pend, w_flush_pend_n;
  logic [BUF_W-1:0] r_out_buf;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_word_valid;

  logic w_accept, w_out_free, w_full, w_flush_req, w_xfer;

  assign w_full     = (r_acc_cnt == CNT_W'(DEPTH));
  assign w_out_free = !r_word_valid || word_ready;
  // test_ending is checked here too so a same-cycle code is refused, not lost.
  assign code_ready = !reset && (r_state == ST_RUN) && !test_ending &&
                      !(w_full && r_word_valid && !word_ready);
  assign w_accept   = code_valid && code_ready;
  assign w_flush_req = r_flush_pend || (flush && (r_state == ST_RUN)) ||
                       (r_state == ST_DRAIN);

  always_comb begin
    w_sum_buf   = w_accept ? dct_shift_in(r_acc_buf, code) : r_acc_buf;
    w_sum_cnt   = r_acc_cnt + CNT_W'(w_accept);
    w_xfer      = 1'b0;
    w_xfer_buf  = r_acc_buf;
    w_xfer_cnt  = r_acc_cnt;
    w_acc_buf_n = r_acc_buf;
    w_acc_cnt_n = r_acc_cnt;
    if (w_full) begin
      // A full accumulator can only still be here because the output was busy;
      // a code accepted while it drains starts the next word.
      w_xfer = w_out_free;
      if (w_xfer) begin
        w_acc_buf_n = w_accept ? BUF_W'(code) : '0;
        w_acc_cnt_n = CNT_W'(w_accept);
      end
    end else begin
      w_xfer_buf = w_sum_buf;
      w_xfer_cnt = w_sum_cnt;
      w_xfer     = ((w_sum_cnt == CNT_W'(DEPTH)) || w_flush_req) &&
                   (w_sum_cnt != '0) && w_out_free;
      if (w_xfer) begin
        w_acc_buf_n = '0;
        w_acc_cnt_n = '0;
      end else begin
        w_acc_buf_n = w_sum_buf;
        w_acc_cnt_n = w_sum_cnt;
      end
    end
    // A flush with nothing left to send simply evaporates.
    w_flush_pend_n = w_flush_req && (w_acc_cnt_n != '0);
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_RUN:   if (test_ending) w_state_n = ST_DRAIN;
      ST_DRAIN: if ((r_acc_cnt == '0) && w_out_free) w_state_n = ST_DONE;
      ST_DONE:  w_state_n = ST_DONE;
      default:  w_state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_acc_buf    <= '0;
      r_acc_cnt    <= '0;
      r_flush_pend <= 1'b0;
      r_out_buf    <= '0;
      r_out_cnt    <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_acc_buf    <= w_acc_buf_n;
      r_acc_cnt    <= w_acc_cnt_n;
      r_flush_pend <= w_flush_pend_n;
      if (w_xfer) begin
        r_out_buf    <= w_xfer_buf;
        r_out_cnt    <= w_xfer_cnt;
        r_word_valid <= 1'b1;
      end else if (word_ready) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  assign word_valid     = r_word_valid;
  assign dct_buffer     = r_out_buf;
  assign dct_count      = r_out_cnt;
  assign test_has_ended = (r_state == ST_DONE);

endmodule
